// File: rtl/tracker_pkg.sv
// Shared definitions for the tracker front-end controller.
// Mode encodings double as the scheduler state encoding.
package tracker_pkg;

    localparam int DISP_W = 16;

    localparam logic [1:0] MODE_STEP = 2'd0;
    localparam logic [1:0] MODE_DIST = 2'd1;
    localparam logic [1:0] MODE_ACT  = 2'd2;
    localparam logic [1:0] MODE_CLR  = 2'd3;

    localparam logic [DISP_W-1:0] SAT16 = 16'hFFFF;

    typedef enum logic [1:0] {
        S_STEP = MODE_STEP,
        S_DIST = MODE_DIST,
        S_ACT  = MODE_ACT,
        S_CLR  = MODE_CLR
    } state_t;

    function automatic state_t next_mode(input state_t s);
        unique case (s)
            S_STEP:  return S_DIST;
            S_DIST:  return S_ACT;
            default: return S_STEP;
        endcase
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge strobe.
// Output is high for one cycle, two edges after the first high sample.
module pulse_sync_edge (
    input  logic clk100Mhz,
    input  logic rst,
    input  logic din,
    output logic strobe
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk100Mhz or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            prev   <= 1'b0;
            strobe <= 1'b0;
        end else begin
            s1     <= din;
            s2     <= s1;
            prev   <= s2;
            strobe <= s2 & ~prev;
        end
    end

endmodule

// File: rtl/tracker_ctrl_scheduler.sv
// Step-counter front end: input sync, clear sequencing, activity
// measurement and rotation of the shared display.
module tracker_ctrl_scheduler
    import tracker_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100000000,
    parameter int unsigned DWELL_SEC     = 2,
    parameter int unsigned ACTIVE_THRESH = 32,
    parameter int unsigned CLR_CYCLES    = 2
) (
    input  logic              clk100Mhz,
    input  logic              rst,
    input  logic              rawPulse,
    input  logic              clearReq,
    input  logic [DISP_W-1:0] stepdisplay,
    input  logic [DISP_W-1:0] distancedisplay,
    input  logic              OFLOW,
    output logic              pulseSignal,
    output logic              counterRst,
    output logic              secTick,
    output logic [1:0]        dispMode,
    output logic [DISP_W-1:0] dispValue,
    output logic [DISP_W-1:0] activeSec
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DWELL_SEC + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_SEC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [7:0]    THRESH     = 8'(ACTIVE_THRESH);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] dwell;
    logic [CW-1:0] clr_cnt;
    logic [7:0]    steps;
    logic          pulse_raw;
    logic          clr_raw;
    logic          in_clr;
    logic          clr_go;
    logic          zero;

    pulse_sync_edge u_pulse_sync (
        .clk100Mhz (clk100Mhz),
        .rst       (rst),
        .din       (rawPulse),
        .strobe    (pulse_raw)
    );

    pulse_sync_edge u_clear_sync (
        .clk100Mhz (clk100Mhz),
        .rst       (rst),
        .din       (clearReq),
        .strobe    (clr_raw)
    );

    // Clear edges seen while already clearing are dropped.
    assign in_clr      = (state == S_CLR);
    assign clr_go      = clr_raw & ~in_clr;
    assign zero        = clr_go | in_clr;
    assign pulseSignal = pulse_raw & ~in_clr;
    assign dispMode    = state;

    always_ff @(posedge clk100Mhz or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            secTick  <= 1'b0;
        end else if (zero) begin
            tick_cnt <= '0;
            secTick  <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            secTick  <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            secTick  <= 1'b0;
        end
    end

    // A pulse landing on the tick belongs to the new second.
    always_ff @(posedge clk100Mhz or negedge rst) begin
        if (!rst) begin
            steps     <= '0;
            activeSec <= '0;
        end else if (zero) begin
            steps     <= '0;
            activeSec <= '0;
        end else if (secTick) begin
            if (steps >= THRESH && activeSec != SAT16)
                activeSec <= activeSec + 1'b1;
            steps <= pulseSignal ? 8'd1 : 8'd0;
        end else if (pulseSignal && steps != 8'hFF) begin
            steps <= steps + 1'b1;
        end
    end

    always_ff @(posedge clk100Mhz or negedge rst) begin
        if (!rst) begin
            state      <= S_STEP;
            dwell      <= '0;
            clr_cnt    <= '0;
            counterRst <= 1'b0;
        end else if (clr_go) begin
            state      <= S_CLR;
            dwell      <= '0;
            clr_cnt    <= '0;
            counterRst <= 1'b1;
        end else if (in_clr) begin
            dwell <= '0;
            if (clr_cnt == CLR_LAST) begin
                state      <= S_STEP;
                clr_cnt    <= '0;
                counterRst <= 1'b0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end else if (OFLOW) begin
            state <= S_STEP;
            dwell <= '0;
        end else if (secTick) begin
            if (dwell == DWELL_LAST) begin
                dwell <= '0;
                state <= next_mode(state);
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100Mhz or negedge rst) begin
        if (!rst) begin
            dispValue <= '0;
        end else begin
            unique case (state)
                S_STEP:  dispValue <= stepdisplay;
                S_DIST:  dispValue <= distancedisplay;
                S_ACT:   dispValue <= activeSec;
                default: dispValue <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_ctrl_scheduler.sv
// Directed bench for tracker_ctrl_scheduler with a strobe scoreboard.
// Small parameters keep seconds ten cycles long.
module tb_tracker_ctrl_scheduler;

    logic        clk100Mhz = 1'b0;
    logic        rst = 1'b0;
    logic        rawPulse = 1'b0;
    logic        clearReq = 1'b0;
    logic [15:0] stepdisplay = 16'd1234;
    logic [15:0] distancedisplay = 16'd5;
    logic        OFLOW = 1'b0;
    logic        pulseSignal;
    logic        counterRst;
    logic        secTick;
    logic [1:0]  dispMode;
    logic [15:0] dispValue;
    logic [15:0] activeSec;

    int errors = 0;
    int total  = 0;
    int cyc    = 0;
    int pulse_q[$];
    int R;
    int R2;

    tracker_ctrl_scheduler #(
        .TICK_DIV      (10),
        .DWELL_SEC     (2),
        .ACTIVE_THRESH (3),
        .CLR_CYCLES    (2)
    ) dut (
        .clk100Mhz       (clk100Mhz),
        .rst             (rst),
        .rawPulse        (rawPulse),
        .clearReq        (clearReq),
        .stepdisplay     (stepdisplay),
        .distancedisplay (distancedisplay),
        .OFLOW           (OFLOW),
        .pulseSignal     (pulseSignal),
        .counterRst      (counterRst),
        .secTick         (secTick),
        .dispMode        (dispMode),
        .dispValue       (dispValue),
        .activeSec       (activeSec)
    );

    always #5 clk100Mhz = ~clk100Mhz;

    always @(posedge clk100Mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every strobe must match the next expected cycle in the queue.
    always @(negedge clk100Mhz) begin
        if (rst && pulseSignal === 1'b1) begin
            int exp_cyc;
            exp_cyc = (pulse_q.size() == 0) ? -1 : pulse_q.pop_front();
            check("pulse_cyc", cyc, exp_cyc);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk100Mhz);
            #1;
        end
    endtask

    task automatic pulse_at(input int k, input bit expect_out);
        goto(k);
        rawPulse = 1'b1;
        if (expect_out) pulse_q.push_back(k + 3);
        goto(k + 1);
        rawPulse = 1'b0;
    endtask

    initial begin
        goto(3);
        check("rst_pulse", pulseSignal, 0);
        check("rst_crst", counterRst, 0);
        check("rst_tick", secTick, 0);
        check("rst_mode", dispMode, 0);
        check("rst_value", dispValue, 0);
        check("rst_active", activeSec, 0);
        rst = 1'b1;
        R = cyc;

        goto(R + 9);
        check("tick_early", secTick, 0);
        goto(R + 10);
        check("tick_first", secTick, 1);
        goto(R + 19);
        check("rot_mode0", dispMode, 0);
        check("rot_val0", dispValue, 1234);
        goto(R + 21);
        check("rot_mode1", dispMode, 1);
        goto(R + 22);
        check("rot_val1", dispValue, 5);
        goto(R + 41);
        check("rot_mode2", dispMode, 2);
        goto(R + 42);
        check("rot_val2", dispValue, 0);
        goto(R + 61);
        check("rot_wrap", dispMode, 0);

        rawPulse = 1'b1;
        pulse_q.push_back(R + 64);
        goto(R + 64);
        check("p1_high", pulseSignal, 1);
        goto(R + 65);
        check("p1_low", pulseSignal, 0);
        goto(R + 66);
        rawPulse = 1'b0;
        goto(R + 68);
        rawPulse = 1'b1;
        pulse_q.push_back(R + 71);
        goto(R + 70);
        rawPulse = 1'b0;

        pulse_at(R + 79, 1'b1);
        goto(R + 81);
        check("act_below", activeSec, 0);
        pulse_at(R + 82, 1'b1);
        pulse_at(R + 85, 1'b1);
        pulse_at(R + 89, 1'b1);
        goto(R + 91);
        check("act_one", activeSec, 1);
        pulse_at(R + 92, 1'b1);
        pulse_at(R + 97, 1'b1);
        goto(R + 100);
        check("coinc_tick", secTick, 1);
        check("coinc_pulse", pulseSignal, 1);
        pulse_at(R + 100, 1'b1);
        goto(R + 101);
        check("act_hold", activeSec, 1);
        goto(R + 102);
        check("act_disp1", dispValue, 1);
        pulse_at(R + 103, 1'b1);
        goto(R + 111);
        check("act_coinc", activeSec, 2);
        goto(R + 112);
        check("act_disp2", dispValue, 2);

        goto(R + 145);
        check("of_pre", dispMode, 1);
        OFLOW = 1'b1;
        stepdisplay = 16'd9999;
        goto(R + 146);
        check("of_mode", dispMode, 0);
        goto(R + 147);
        check("of_val", dispValue, 9999);
        goto(R + 200);
        check("of_hold1", dispMode, 0);
        goto(R + 245);
        check("of_hold2", dispMode, 0);
        check("of_hval", dispValue, 9999);
        OFLOW = 1'b0;
        pulse_at(R + 258, 1'b1);
        goto(R + 260);
        check("of_resume0", dispMode, 0);
        goto(R + 261);
        check("of_resume1", dispMode, 1);
        pulse_at(R + 261, 1'b1);
        pulse_at(R + 264, 1'b1);
        pulse_at(R + 268, 1'b1);
        goto(R + 271);
        check("act_three", activeSec, 3);
        pulse_at(R + 271, 1'b1);
        pulse_at(R + 274, 1'b1);
        goto(R + 281);
        check("act_four", activeSec, 4);
        goto(R + 282);
        check("act_disp4", dispValue, 4);

        goto(R + 283);
        clearReq = 1'b1;
        pulse_at(R + 284, 1'b0);
        goto(R + 286);
        clearReq = 1'b0;
        check("clr_pre_mode", dispMode, 2);
        check("clr_pre_rst", counterRst, 0);
        goto(R + 287);
        check("clr_mode", dispMode, 3);
        check("clr_rst1", counterRst, 1);
        check("clr_active", activeSec, 0);
        check("clr_gate", pulseSignal, 0);
        goto(R + 288);
        check("clr_rst2", counterRst, 1);
        check("clr_val", dispValue, 0);
        goto(R + 289);
        check("clr_rst_end", counterRst, 0);
        check("clr_exit", dispMode, 0);
        goto(R + 298);
        check("clr_tick_early", secTick, 0);
        goto(R + 299);
        check("clr_tick", secTick, 1);
        goto(R + 309);
        check("clr_dwell0", dispMode, 0);
        goto(R + 310);
        check("clr_dwell1", dispMode, 1);

        goto(R + 320);
        clearReq = 1'b1;
        goto(R + 321);
        clearReq = 1'b0;
        goto(R + 324);
        check("ar_crst", counterRst, 1);
        check("ar_val_pre", dispValue, 5);
        #2;
        rst = 1'b0;
        #1;
        check("ar_crst0", counterRst, 0);
        check("ar_mode0", dispMode, 0);
        check("ar_val0", dispValue, 0);
        check("ar_act0", activeSec, 0);
        check("ar_tick0", secTick, 0);
        check("ar_pulse0", pulseSignal, 0);
        goto(R + 328);
        rst = 1'b1;
        R2 = cyc;
        goto(R2 + 1);
        check("rel_mode", dispMode, 0);
        check("rel_crst", counterRst, 0);
        goto(R2 + 9);
        check("rel_tick_early", secTick, 0);
        goto(R2 + 10);
        check("rel_tick", secTick, 1);

        goto(R2 + 14);
        check("pulse_q_empty", pulse_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule

// File: doc/tracker_ctrl_scheduler.md
Name: tracker_ctrl_scheduler

Overview:
Front-end controller for the step-counter datapath in the fitness tracker.
- Synchronises the raw pedometer input and issues one-cycle pulseSignal strobes to the counter.
- Sequences a user clear, issuing the counter's synchronous active-high reset.
- Measures per-second activity and rotates the shared 16-bit display between steps, distance and active-seconds.

Parameters:
TICK_DIV, 100000000, clk100Mhz cycles per one-second tick
DWELL_SEC, 2, seconds each display mode is shown before rotating
ACTIVE_THRESH, 32, minimum steps in one second for that second to count as active
CLR_CYCLES, 2, cycles counterRst is held high during a clear

Ports:
clk100Mhz  in  1  system clock
rst  in  1  asynchronous, active-low reset
rawPulse  in  1  asynchronous pedometer pulse
clearReq  in  1  asynchronous user clear button, active-high
stepdisplay  in  16  step display value from counter (saturates 9999)
distancedisplay  in  16  distance value from counter
OFLOW  in  1  counter overflow flag
pulseSignal  out  1  one-cycle step strobe to counter
counterRst  out  1  synchronous active-high reset to counter
secTick  out  1  one-cycle strobe per second
dispMode  out  2  0=steps, 1=distance, 2=active seconds, 3=clearing
dispValue  out  16  value to drive display
activeSec  out  16  saturating count of active seconds

Behaviour:
- Reset: rst low asynchronously forces every output, counter and register to 0; FSM to S_STEP. Takes effect immediately mid-operation; release is synchronous to the next edge.
- Input sync: rawPulse and clearReq each pass through 2-flop synchroniser plus rising-edge detector.
  - If rawPulse is first sampled high at edge N, pulseSignal is high for exactly the cycle after edge N+2.
  - A held input yields one strobe only. A new strobe needs a low sample first.
- Tick divider: counts 0..TICK_DIV-1; secTick is high in the cycle after the counter reaches TICK_DIV-1; counter then wraps to 0.
- Rate counter: 8-bit stepsThisSec, saturating at 255, increments on each pulseSignal.
  - On secTick: if stepsThisSec >= ACTIVE_THRESH and activeSec != 16'hFFFF, activeSec increments. stepsThisSec then loads 0.
  - If pulseSignal coincides with secTick, stepsThisSec loads 1 instead (the pulse counts toward the new second).
- FSM states:
  - S_STEP (mode 0), S_DIST (1), S_ACT (2): on each secTick the dwell counter increments. When it reaches DWELL_SEC it resets to 0 and the state advances S_STEP->S_DIST->S_ACT->S_STEP.
  - S_CLR (3): entered from any state on a clearReq edge.
    - counterRst is high for exactly CLR_CYCLES cycles. activeSec, stepsThisSec, tick divider and dwell counter are zeroed.
    - pulseSignal is forced 0 and edges arriving during S_CLR are discarded.
    - Exits to S_STEP. clearReq edges while in S_CLR are ignored.
- Overflow: while OFLOW is high and state is not S_CLR, the next edge forces S_STEP and holds the dwell counter at 0 (rotation frozen, 9999 shown). Clear still has priority over OFLOW.
- Display mux:
  - dispMode is the registered state encoding.
  - dispValue is registered one cycle after dispMode from: stepdisplay / distancedisplay / activeSec / 0 for modes 0/1/2/3.
  - Total latency from input change to dispValue is 1 cycle.
- Widths: activeSec and dispValue 16-bit unsigned; no wrap anywhere, all counters saturate except the tick divider.

Decomposition:
- Shared package tracker_pkg holds:
  - mode encoding localparams MODE_STEP/MODE_DIST/MODE_ACT/MODE_CLR
  - display width 16
  - saturation constant 16'hFFFF
- One natural sub-module: pulse_sync_edge (2-flop synchroniser plus registered rising-edge strobe, async active-low reset). Instantiate it twice, for rawPulse and clearReq.

Test Plan:
All scenarios use TICK_DIV=10, DWELL_SEC=2, ACTIVE_THRESH=3, CLR_CYCLES=2.
1. rawPulse high for 5 cycles, first sampled at edge 4 -> a single pulseSignal during cycle after edge 6; none at any other edge; raise again after a low sample -> second strobe.
2. No activity, distancedisplay=5 -> dispMode 0 for first 20 cycles, 1 after 2nd secTick with dispValue=5 one cycle later, 2 after 4th, back to 0 after 6th.
3. 3 rawPulse edges in second 1, 2 in second 2 -> activeSec=1 after first secTick, still 1 after second; pulse coincident with secTick counted in following second.
4. OFLOW asserted while dispMode=1, stepdisplay=9999 -> dispMode=0 next cycle, dispValue=9999 the cycle after, unchanged across 10 secTicks; deassert -> rotation resumes after 2 ticks.
5. clearReq edge with activeSec=4 -> dispMode=3, counterRst high exactly 2 cycles, activeSec=0, rawPulse edge inside window produces no pulseSignal, then dispMode=0 with dwell restarted.
6. rst driven low mid-rotation while counterRst high -> all outputs 0 immediately (asynchronously); after release dispMode=0 and first secTick 10 cycles later.
